// File: rtl/video_in_wb_dma.sv
// ---------------------------------------------------------------------------
// video_in_wb_dma
// Drains 32-bit pixel packs (4 pixels each) from the video input FIFO and
// writes them into the RAM frame buffer as fixed-length, locked Wishbone
// write bursts. Raises a level interrupt once a full frame has been stored,
// or when the slave terminates a beat with ERR_I.
//
// Ports
//   clk, nRST            clock, synchronous active-low reset
//   data_fifo            FIFO head word (first-word-fall-through)
//   nb_pack_available    words currently held in the FIFO
//   r_ack                pop strobe, one per word accepted by the slave
//   wb_reg_data          frame buffer byte base address (bits [1:0] ignored)
//   wb_reg_ctr           [0] enable, [1] interrupt clear (level)
//   interrupt            frame-done / bus-error interrupt (level)
//   p_wb_*_O             Wishbone master write outputs
//   p_wb_ACK_I/ERR_I     Wishbone slave acknowledge / error
// ---------------------------------------------------------------------------
module video_in_wb_dma #(
   parameter int unsigned FRAME_W   = 640,
   parameter int unsigned FRAME_H   = 480,
   parameter int unsigned BURST_LEN = 8,
   parameter int unsigned CNT_W     = 6
) (
   input  logic             clk,
   input  logic             nRST,
   input  logic [31:0]      data_fifo,
   input  logic [CNT_W-1:0] nb_pack_available,
   output logic             r_ack,
   input  logic [31:0]      wb_reg_data,
   input  logic [31:0]      wb_reg_ctr,
   output logic             interrupt,
   output logic             p_wb_CYC_O,
   output logic             p_wb_STB_O,
   output logic             p_wb_LOCK_O,
   output logic [3:0]       p_wb_SEL_O,
   output logic [31:0]      p_wb_ADR_O,
   output logic [31:0]      p_wb_DAT_O,
   input  logic             p_wb_ACK_I,
   input  logic             p_wb_ERR_I
);

   localparam int unsigned FRAME_WORDS = FRAME_W * FRAME_H / 4;
   localparam int unsigned WCNT_W      = $clog2(FRAME_WORDS + 1);
   localparam int unsigned BCNT_W      = $clog2(BURST_LEN + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT,
      S_BURST,
      S_DONE,
      S_ERR
   } state_t;

   state_t              state;
   state_t              state_nxt;
   logic                bus_on;
   logic [31:0]         base;
   logic [31:0]         adr;
   logic [WCNT_W-1:0]   wcnt;
   logic [BCNT_W-1:0]   bcnt;
   logic                stop_seen;
   logic                irq_q;
   logic                err_q;

   logic                enable;
   logic                irq_clr;
   logic                in_burst;
   logic                beat_ack;
   logic                beat_err;
   logic                frame_end;
   logic                last_beat;
   logic                stop_now;
   logic                irq_set;
   logic                fifo_ready;
   logic                unused_bits;

   assign enable      = wb_reg_ctr[0];
   assign irq_clr     = wb_reg_ctr[1];
   assign unused_bits = ^{wb_reg_data[1:0], wb_reg_ctr[31:2]};

   // Beat qualification; ERR_I overrides a simultaneous ACK_I.
   assign in_burst   = (state == S_BURST);
   assign beat_err   = in_burst & p_wb_ERR_I;
   assign beat_ack   = in_burst & p_wb_ACK_I & ~p_wb_ERR_I;
   assign frame_end  = ((32'(wcnt) + 32'd1) == FRAME_WORDS);
   // A burst also closes on the last word of the frame, so the frame never overruns.
   assign last_beat  = beat_ack & ((bcnt == BCNT_W'(BURST_LEN - 1)) | frame_end);
   // Disable seen at any point of the burst takes effect once the burst closes.
   assign stop_now   = stop_seen | ~enable;
   assign irq_set    = (state == S_DONE) | beat_err;
   assign fifo_ready = (32'(nb_pack_available) >= BURST_LEN);

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (enable) state_nxt = S_WAIT;
         S_WAIT: begin
            if (!enable)         state_nxt = S_IDLE;
            else if (fifo_ready) state_nxt = S_BURST;
         end
         S_BURST: begin
            if (beat_err)       state_nxt = S_ERR;
            else if (last_beat) begin
               if (frame_end)     state_nxt = S_DONE;
               else if (stop_now) state_nxt = S_IDLE;
               else               state_nxt = S_WAIT;
            end
         end
         S_DONE:  state_nxt = S_IDLE;
         S_ERR:   if (!enable) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // State, counters, address and interrupt flags
   always_ff @(posedge clk) begin
      if (!nRST) begin
         state     <= S_IDLE;
         bus_on    <= 1'b0;
         base      <= '0;
         adr       <= '0;
         wcnt      <= '0;
         bcnt      <= '0;
         stop_seen <= 1'b0;
         irq_q     <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state  <= state_nxt;
         bus_on <= (state_nxt == S_BURST);

         // New frame: latch word-aligned base and restart the word count.
         if (state == S_IDLE && enable) begin
            base <= {wb_reg_data[31:2], 2'b00};
            wcnt <= '0;
         end

         if (!in_burst && state_nxt == S_BURST) begin
            bcnt      <= '0;
            stop_seen <= 1'b0;
         end else if (in_burst) begin
            if (!enable) stop_seen <= 1'b1;
            if (beat_ack) begin
               wcnt <= wcnt + WCNT_W'(1);
               bcnt <= bcnt + BCNT_W'(1);
            end
         end

         // Address is base + 4*wcnt, advanced by one word per accepted beat.
         if (state_nxt != S_BURST)  adr <= '0;
         else if (!in_burst)        adr <= base + (32'(wcnt) << 2);
         else if (beat_ack)         adr <= adr + 32'd4;

         // Setting has priority over the level clear.
         if (irq_set)      irq_q <= 1'b1;
         else if (irq_clr) irq_q <= 1'b0;

         if (beat_err)     err_q <= 1'b1;
         else if (irq_clr) err_q <= 1'b0;
      end
   end

   assign p_wb_CYC_O  = bus_on;
   assign p_wb_STB_O  = bus_on;
   assign p_wb_LOCK_O = bus_on;
   assign p_wb_SEL_O  = {4{bus_on}};
   assign p_wb_ADR_O  = adr;
   // Write data comes straight from the FWFT head; the pop follows the slave's ACK.
   assign p_wb_DAT_O  = bus_on ? data_fifo : 32'd0;
   assign r_ack       = beat_ack;
   assign interrupt   = irq_q | err_q;

endmodule

// File: tb/tb_video_in_wb_dma.sv
// ---------------------------------------------------------------------------
// tb_video_in_wb_dma
// Bench for video_in_wb_dma with a small frame (16x4 pixels = 16 words) and
// 4-word bursts. A queue models the FWFT FIFO; a slave model answers beats
// with configurable wait states / one-shot error and checks every beat
// against the expected frame address and FIFO head word.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_video_in_wb_dma;

   localparam int unsigned FRAME_W   = 16;
   localparam int unsigned FRAME_H   = 4;
   localparam int unsigned BURST_LEN = 4;
   localparam int unsigned CNT_W     = 6;

   logic             clk = 1'b0;
   logic             nRST;
   logic [31:0]      data_fifo;
   logic [CNT_W-1:0] nb_pack_available;
   logic             r_ack;
   logic [31:0]      wb_reg_data;
   logic [31:0]      wb_reg_ctr;
   logic             interrupt;
   logic             p_wb_CYC_O;
   logic             p_wb_STB_O;
   logic             p_wb_LOCK_O;
   logic [3:0]       p_wb_SEL_O;
   logic [31:0]      p_wb_ADR_O;
   logic [31:0]      p_wb_DAT_O;
   logic             p_wb_ACK_I;
   logic             p_wb_ERR_I;

   always #5 clk = ~clk;

   video_in_wb_dma #(
      .FRAME_W   (FRAME_W),
      .FRAME_H   (FRAME_H),
      .BURST_LEN (BURST_LEN),
      .CNT_W     (CNT_W)
   ) dut (
      .clk               (clk),
      .nRST              (nRST),
      .data_fifo         (data_fifo),
      .nb_pack_available (nb_pack_available),
      .r_ack             (r_ack),
      .wb_reg_data       (wb_reg_data),
      .wb_reg_ctr        (wb_reg_ctr),
      .interrupt         (interrupt),
      .p_wb_CYC_O        (p_wb_CYC_O),
      .p_wb_STB_O        (p_wb_STB_O),
      .p_wb_LOCK_O       (p_wb_LOCK_O),
      .p_wb_SEL_O        (p_wb_SEL_O),
      .p_wb_ADR_O        (p_wb_ADR_O),
      .p_wb_DAT_O        (p_wb_DAT_O),
      .p_wb_ACK_I        (p_wb_ACK_I),
      .p_wb_ERR_I        (p_wb_ERR_I)
   );

   int n_chk  = 0;
   int n_fail = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Reference state: FIFO contents, frame base and word index of the next write.
   logic [31:0] fifo_q[$];
   logic [31:0] m_base      = 32'd0;
   int          m_idx       = 0;
   int          ws          = 0;
   int          err_beat    = -1;
   int          ws_cnt      = 0;
   int          beat_in_bst = 0;
   bit          pop_pending = 1'b0;
   int          wr_count    = 0;
   int          stb_cycles  = 0;
   logic [31:0] last_adr    = 32'd0;
   logic [31:0] beat_adr    = 32'd0;
   logic [31:0] beat_dat    = 32'd0;

   // FIFO + Wishbone slave model, acting on the falling edge.
   always @(negedge clk) begin : slave_model
      logic        ack_v;
      logic        err_v;
      logic        first;
      logic [31:0] exp_dat;
      if (pop_pending && fifo_q.size() > 0) fifo_q.delete(0);
      pop_pending = 1'b0;
      data_fifo = (fifo_q.size() > 0) ? fifo_q[0] : 32'd0;
      nb_pack_available = (fifo_q.size() > 63) ? CNT_W'(63) : CNT_W'(fifo_q.size());
      exp_dat = data_fifo;
      ack_v = 1'b0;
      err_v = 1'b0;
      if (!p_wb_CYC_O) begin
         beat_in_bst = 0;
         ws_cnt      = 0;
      end
      first = (ws_cnt == 0);
      if (p_wb_STB_O) begin
         stb_cycles++;
         if (ws_cnt < ws) ws_cnt++;
         else begin
            ws_cnt = 0;
            if (beat_in_bst == err_beat) begin
               err_v    = 1'b1;
               err_beat = -1;
            end else ack_v = 1'b1;
         end
      end
      p_wb_ACK_I = ack_v;
      p_wb_ERR_I = err_v;
      #1;
      if (p_wb_STB_O) begin
         if (first) begin
            check_eq("beat_adr", p_wb_ADR_O, m_base + 32'(m_idx) * 32'd4);
            check_eq("beat_dat", p_wb_DAT_O, exp_dat);
            beat_adr = p_wb_ADR_O;
            beat_dat = p_wb_DAT_O;
         end else begin
            check_eq("wait_adr_stable", p_wb_ADR_O, beat_adr);
            check_eq("wait_dat_stable", p_wb_DAT_O, beat_dat);
         end
         check_eq("bus_ctl", 32'({p_wb_CYC_O, p_wb_LOCK_O, p_wb_SEL_O}), 32'h3F);
      end else begin
         check_eq("bus_idle", 32'({p_wb_CYC_O, p_wb_LOCK_O, p_wb_SEL_O}), 32'h0);
      end
      check_eq("r_ack", 32'(r_ack), 32'(ack_v));
      if (ack_v) begin
         pop_pending = 1'b1;
         wr_count++;
         last_adr = m_base + 32'(m_idx) * 32'd4;
         m_idx++;
         beat_in_bst++;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
      #3;
   endtask

   task automatic push(input int n);
      for (int i = 0; i < n; i++) fifo_q.push_back($urandom);
   endtask

   task automatic wait_irq(input string tag, input int budget);
      int c = 0;
      while (interrupt !== 1'b1 && c < budget) begin
         tick(1);
         c++;
      end
      check_eq(tag, 32'(interrupt), 32'd1);
   endtask

   task automatic wait_writes(input string tag, input int target, input int budget);
      int c = 0;
      while (wr_count < target && c < budget) begin
         tick(1);
         c++;
      end
      check_eq(tag, 32'(wr_count), 32'(target));
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin : stimulus
      int w0;
      int c;
      nRST        = 1'b0;
      wb_reg_data = 32'd0;
      wb_reg_ctr  = 32'd0;
      tick(3);
      check_eq("rst_bus", 32'({p_wb_CYC_O, p_wb_STB_O, p_wb_LOCK_O, p_wb_SEL_O}), 32'h0);
      check_eq("rst_adr", p_wb_ADR_O, 32'h0);
      check_eq("rst_dat", p_wb_DAT_O, 32'h0);
      check_eq("rst_irq_rack", 32'({interrupt, r_ack}), 32'h0);
      nRST = 1'b1;
      tick(2);

      // Whole frame, zero wait states; base bits [1:0] must be dropped.
      wb_reg_data = 32'h0000_1003;
      m_base = 32'h0000_1000;
      m_idx  = 0;
      w0     = wr_count;
      push(16);
      wb_reg_ctr = 32'd1;
      wait_irq("t1_irq", 400);
      check_eq("t1_words", 32'(wr_count - w0), 32'd16);
      check_eq("t1_last_adr", last_adr, 32'h0000_103C);
      wb_reg_ctr = 32'd0;
      tick(3);
      check_eq("t1_irq_held", 32'(interrupt), 32'd1);
      wb_reg_ctr = 32'd2;
      tick(1);
      wb_reg_ctr = 32'd0;
      check_eq("t1_irq_clr", 32'(interrupt), 32'd0);

      // Fewer than BURST_LEN words: no bus activity.
      wb_reg_data = 32'h0000_2000;
      m_base = 32'h0000_2000;
      m_idx  = 0;
      w0     = wr_count;
      push(3);
      wb_reg_ctr = 32'd1;
      stb_cycles = 0;
      tick(100);
      check_eq("t2_no_stb", 32'(stb_cycles), 32'd0);
      check_eq("t2_no_pop", 32'(wr_count - w0), 32'd0);

      // 4th word arrives; burst with 2 wait states per beat.
      ws = 2;
      push(1);
      c = 0;
      while (p_wb_CYC_O !== 1'b1 && c < 4) begin
         tick(1);
         c++;
      end
      check_eq("t2_start_latency", 32'(c <= 2), 32'd1);
      wait_writes("t3_words", w0 + 4, 100);
      tick(2);
      check_eq("t3_burst_cycles", 32'(stb_cycles), 32'd12);
      check_eq("t3_last_adr", last_adr, 32'h0000_200C);
      ws = 0;

      // ERR on the 2nd beat.
      w0 = wr_count;
      stb_cycles = 0;
      err_beat = 1;
      push(4);
      wait_irq("t4_irq", 100);
      check_eq("t4_one_pop", 32'(wr_count - w0), 32'd1);
      check_eq("t4_cyc_drop", 32'(stb_cycles), 32'd2);
      push(4);
      tick(20);
      check_eq("t4_stays_halted", 32'(stb_cycles), 32'd2);
      check_eq("t4_irq_held", 32'(interrupt), 32'd1);
      wb_reg_ctr = 32'd3;
      tick(1);
      wb_reg_ctr = 32'd1;
      check_eq("t4_irq_clr", 32'(interrupt), 32'd0);
      wb_reg_ctr = 32'd0;
      tick(2);

      // Full frame after re-enable; clear held high so the set must win.
      wb_reg_data = 32'h0000_3000;
      m_base = 32'h0000_3000;
      m_idx  = 0;
      push(9);
      w0 = wr_count;
      wb_reg_ctr = 32'd1;
      wait_writes("t5_partial", w0 + 5, 100);
      wb_reg_data = 32'h0000_5000;
      wb_reg_ctr  = 32'd3;
      wait_irq("t5_irq_set_wins", 300);
      check_eq("t5_words", 32'(wr_count - w0), 32'd16);
      check_eq("t5_last_adr", last_adr, 32'h0000_303C);
      tick(1);
      check_eq("t5_irq_clr", 32'(interrupt), 32'd0);
      wb_reg_ctr = 32'd1;
      m_base = 32'h0000_5000;
      m_idx  = 0;
      w0 = wr_count;
      push(4);
      wait_writes("t5_next_frame", w0 + 4, 100);
      check_eq("t5_new_base", last_adr, 32'h0000_500C);

      // Reset asserted while the 3rd beat is on the bus.
      w0 = wr_count;
      push(4);
      c = 0;
      while (!((wr_count - w0) == 3 && p_wb_STB_O === 1'b1) && c < 50) begin
         tick(1);
         c++;
      end
      check_eq("t6_reach_beat3", 32'(wr_count - w0), 32'd3);
      nRST = 1'b0;
      tick(1);
      check_eq("t6_bus_off", 32'({p_wb_CYC_O, p_wb_STB_O, p_wb_LOCK_O, p_wb_SEL_O, r_ack}), 32'h0);
      check_eq("t6_adr_off", p_wb_ADR_O, 32'h0);
      check_eq("t6_irq_off", 32'(interrupt), 32'd0);
      tick(2);
      check_eq("t6_no_more_pops", 32'(wr_count - w0), 32'd3);
      nRST  = 1'b1;
      m_idx = 0;
      tick(1);
      push(3);
      wait_writes("t6_restart_words", w0 + 7, 100);
      check_eq("t6_restart_adr", last_adr, 32'h0000_500C);

      tick(2);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
